// File: rtl/itcm_arbiter.sv
// Two-requester (IFU fetch / LSU data) arbiter and sequencer for the single-port ITCM SRAM.
// Optional ITCM_ARB_RR_EN selects round-robin arbitration; the default is fixed priority, LSU over IFU.
module itcm_arbiter #(
  parameter int AW = 14,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_valid,
  input  logic            ifu_rsp_ready,
  output logic [DW-1:0]   ifu_rsp_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic            lsu_req_we,
  input  logic [DW/8-1:0] lsu_req_wem,
  input  logic [DW-1:0]   lsu_req_wdata,
  output logic            lsu_rsp_valid,
  input  logic            lsu_rsp_ready,
  output logic [DW-1:0]   lsu_rsp_rdata,
  output logic            sram_cs,
  output logic            sram_we,
  output logic [DW/8-1:0] sram_wem,
  output logic [AW-1:0]   sram_addr,
  output logic [DW-1:0]   sram_wdata,
  input  logic [DW-1:0]   sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;        // 1 = LSU owns the in-flight access
  logic          owner_we_q, owner_we_d;
  logic [DW-1:0] buf_q, buf_d;

  logic          rsp_busy;
  logic          owner_rsp_ready;
  logic          free;
  logic          lsu_wins;
  logic          grant;
  logic [DW-1:0] rsp_data;

  assign rsp_busy        = (state_q != IDLE);
  assign owner_rsp_ready = owner_q ? lsu_rsp_ready : ifu_rsp_ready;
  // rst_n gates the grant so req_ready and sram_* read 0 for the whole reset window.
  assign free            = rst_n && (!rsp_busy || owner_rsp_ready);

`ifdef ITCM_ARB_RR_EN
  logic rr_last_q, rr_last_d;             // 1 = LSU was granted last

  assign lsu_wins  = lsu_req_valid && (!ifu_req_valid || !rr_last_q);
  assign rr_last_d = grant ? lsu_req_ready : rr_last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_last_q <= 1'b0;
    else        rr_last_q <= rr_last_d;
  end
`else
  assign lsu_wins = lsu_req_valid;
`endif

  assign lsu_req_ready = free && lsu_wins;
  assign ifu_req_ready = free && ifu_req_valid && !lsu_wins;
  assign grant         = lsu_req_ready || ifu_req_ready;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block leaves a latch.
    rsp_data = '0;
    unique case (state_q)
      ACCESS:  rsp_data = owner_we_q ? '0 : sram_rdata;
      HOLD:    rsp_data = buf_q;
      default: rsp_data = '0;
    endcase
  end

  assign ifu_rsp_valid = rsp_busy && !owner_q;
  assign lsu_rsp_valid = rsp_busy && owner_q;
  assign ifu_rsp_rdata = ifu_rsp_valid ? rsp_data : '0;
  assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;

  always_comb begin
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_wem   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (lsu_req_ready) begin
      sram_cs    = 1'b1;
      sram_we    = lsu_req_we;
      sram_wem   = lsu_req_we ? lsu_req_wem : '0;
      sram_addr  = lsu_req_addr;
      sram_wdata = lsu_req_we ? lsu_req_wdata : '0;
    end else if (ifu_req_ready) begin
      sram_cs    = 1'b1;
      sram_addr  = ifu_req_addr;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_we_d = owner_we_q;
    buf_d      = buf_q;
    if (free) begin
      if (grant) begin
        state_d    = ACCESS;
        owner_d    = lsu_req_ready;
        owner_we_d = lsu_req_ready && lsu_req_we;
      end else begin
        state_d    = IDLE;
      end
    end else if (state_q == ACCESS) begin
      // The SRAM output is only valid for one cycle; park it until the owner accepts.
      state_d = HOLD;
      buf_d   = rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      owner_we_q <= 1'b0;
      buf_q      <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q    <= state_d;
      owner_q    <= owner_d;
      owner_we_q <= owner_we_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: doc/itcm_arbiter.md
# itcm_arbiter

Two-requester arbiter and sequencer for the single-port ITCM SRAM inside cpu_top. Shares the ITCM between the IFU instruction-fetch channel (read-only) and the LSU data channel (read/write). Each side has a valid/ready request and response channel. The block drives the SRAM macro, which has 1-cycle read latency. At most one access is in flight, and back-to-back accesses run at one per cycle when responses are accepted immediately.

## Interface
Parameters:
- AW, 14: ITCM word-address width.
- DW, 32: data width; DW/8 byte-enable bits.

Ports:
- clk  in  1  clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU fetch request valid
- ifu_req_ready  out  1  IFU request accepted
- ifu_req_addr  in  AW  fetch word address
- ifu_rsp_valid  out  1  fetch response valid
- ifu_rsp_ready  in  1  IFU accepts response
- ifu_rsp_rdata  out  DW  fetched instruction
- lsu_req_valid  in  1  LSU request valid
- lsu_req_ready  out  1  LSU request accepted
- lsu_req_addr  in  AW  word address
- lsu_req_we  in  1  1 = write, 0 = read
- lsu_req_wem  in  DW/8  byte write mask
- lsu_req_wdata  in  DW  write data
- lsu_rsp_valid  out  1  LSU response valid
- lsu_rsp_ready  in  1  LSU accepts response
- lsu_rsp_rdata  out  DW  read data; 0 for writes
- sram_cs  out  1  SRAM chip select
- sram_we  out  1  SRAM write enable
- sram_wem  out  DW/8  SRAM byte mask
- sram_addr  out  AW  SRAM address
- sram_wdata  out  DW  SRAM write data
- sram_rdata  in  DW  SRAM read data; valid the cycle after a cs with we=0

## Operation
States:
- IDLE: no access in flight.
- ACCESS: SRAM was accessed last cycle; the response is driven directly from sram_rdata, or 0 for a write.
- HOLD: the response is held in the rsp buffer, waiting for rsp_ready.

Registered state: owner (IFU or LSU), owner_we, rsp buffer.

Request acceptance:
- "Free" is true when state=IDLE, or when state is ACCESS/HOLD and the owner's rsp_valid&&rsp_ready completes this cycle.
- When free, the arbitration winner sees req_ready=1. The loser sees req_ready=0.
- A request handshake drives sram_cs=1 in the same cycle, combinationally from the winner's fields, and state goes to ACCESS.
- If free but no request is valid, state goes to IDLE.

ACCESS:
- The owner's rsp_valid=1; rdata = sram_rdata for reads, 0 for writes.
- If rsp_ready=0: capture the rdata value into the buffer and go to HOLD.

HOLD:
- The owner's rsp_valid=1 and rdata comes from the buffer.
- The SRAM is not selected.

Other rules:
- The non-owner's rsp_valid is always 0.
- When sram_cs=0, all other sram_* outputs are 0.
- IFU requests always drive sram_we=0 and sram_wem=0.
- Arbitration, default: fixed priority, LSU over IFU.

## Timing
- Read latency: request handshake in cycle N gives rsp_valid in cycle N+1.
- Throughput: one access per cycle while the owner holds rsp_ready=1 and a requester keeps req_valid=1.
- req_ready depends combinationally on the owner's rsp_ready.
- Response stability: while rsp_valid=1 and rsp_ready=0, rsp_rdata is stable and no new sram_cs is issued.
- Request stability: requesters must keep valid and payload stable until ready.
- Simultaneous events: a response handshake and a new grant in the same cycle are legal. The new owner's response appears the next cycle.
- Reset: async assertion forces IDLE immediately and clears owner, buffer and RR pointer. Any in-flight response is dropped.
- Reset values: all outputs 0 (req_ready, rsp_valid, rsp_rdata, sram_*).

## Configuration
ITCM_ARB_RR_EN:
- Defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated on every request handshake.
  - When both requesters are valid, the one not granted last wins.
  - The pointer resets to "IFU last", so LSU wins the first tie.
  - With a single valid requester, that requester wins and the pointer still updates.
- Undefined: fixed priority, LSU over IFU; the pointer logic is absent. IFU can starve while the LSU requests continuously. This is acceptable because LSU bursts are bounded by the core.

## Test plan
- IFU read, SRAM word 4 preloaded with 0x00100093, ifu_rsp_ready=1: handshake at N, sram_cs=1 and sram_addr=4 at N; ifu_rsp_valid=1 with rdata 0x00100093 at N+1.
- Both requesters valid at N, fixed priority: lsu_req_ready=1 and ifu_req_ready=0 at N. IFU is granted at N+1 together with the LSU response handshake.
- ITCM_ARB_RR_EN, both requesters valid for 4 accesses, rsp_ready=1: grants are LSU, IFU, LSU, IFU on consecutive cycles.
- IFU read, then ifu_rsp_ready=0 for 3 cycles: state HOLD, rdata stable, sram_cs=0, both req_ready=0. Response completes on the first ready=1 cycle.
- LSU write of 0xDEADBEEF, wem=4'b0011, addr 8, over word value 0x12345678: sram_we=1, sram_wem=0011, lsu_rsp_rdata=0. A following read of addr 8 returns 0x1234BEEF.
- rst_n driven low mid-ACCESS: all outputs 0 asynchronously. After release, the first request sees 1-cycle latency and no stale response.
